// File: rtl/br_update_scheduler_if.sv
// Commit bus from the ROB and single update port toward branch_predictor.
interface br_update_scheduler_if #(
    parameter int PORTS = 2
);
    logic [PORTS-1:0]    commit_valid;
    logic [32*PORTS-1:0] commit_pc;
    logic [PORTS-1:0]    commit_taken;
    logic                commit_ready;
    logic                upd_stall;
    logic [31:0]         pc_result;
    logic                br_result;
    logic                pc_result_load;

    modport master (
        input  commit_valid,
        input  commit_pc,
        input  commit_taken,
        input  upd_stall,
        output commit_ready,
        output pc_result,
        output br_result,
        output pc_result_load
    );

    modport slave (
        output commit_valid,
        output commit_pc,
        output commit_taken,
        output upd_stall,
        input  commit_ready,
        input  pc_result,
        input  br_result,
        input  pc_result_load
    );
endinterface

// File: rtl/br_update_scheduler.sv
// Buffers up to PORTS committed branches per cycle and drains them
// one per cycle, in commit order, into the predictor update port.
module br_update_scheduler #(
    parameter int PORTS = 2,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    br_update_scheduler_if.master bus,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_t;

    upd_t mem [DEPTH];

    ptr_t head;
    ptr_t tail;
    cnt_t count;

    ptr_t wr_idx [PORTS];
    cnt_t enq_cnt;
    cnt_t enq_acc;
    logic accept;
    logic load;
    logic any_valid;

    // Ready uses the pre-dequeue count, so a full FIFO refuses even
    // when an update drains in the same cycle.
    assign accept    = (cnt_t'(DEPTH) - count) >= cnt_t'(PORTS);
    assign any_valid = |bus.commit_valid;
    assign load      = (count != '0) && !bus.upd_stall;

    assign bus.commit_ready   = accept;
    assign bus.pc_result_load = load;
    assign bus.pc_result      = mem[head].pc;
    assign bus.br_result      = mem[head].taken;

    // Valid lanes pack densely from tail in ascending lane order.
    always_comb begin
        enq_cnt = '0;
        for (int i = 0; i < PORTS; i++) begin
            wr_idx[i] = tail + enq_cnt[AW-1:0];
            if (bus.commit_valid[i]) begin
                enq_cnt = enq_cnt + cnt_t'(1);
            end
        end
    end

    assign enq_acc = accept ? enq_cnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tail  <= tail + enq_acc[AW-1:0];
            count <= count + enq_acc - cnt_t'(load);
            if (load) begin
                head <= head + ptr_t'(1);
            end
            if (!accept && any_valid) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (accept && bus.commit_valid[i]) begin
                mem[wr_idx[i]].pc    <= bus.commit_pc[32*i +: 32];
                mem[wr_idx[i]].taken <= bus.commit_taken[i];
            end
        end
    end
endmodule
